// File: rtl/wb_dsp_arbiter_if.sv
// wb_dsp_arbiter_if: one Wishbone link (master drives request, slave drives response)
interface wb_dsp_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH/8-1:0] sel;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic                    ack;
  logic                    err;
  modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack, err);
  modport slave  (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/wb_dsp_arbiter.sv
// wb_dsp_arbiter: two-master Wishbone arbiter with cycle lock and per-transfer watchdog
module wb_dsp_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int PRIORITY_MODE = 0,
  parameter int TIMEOUT       = 255,
  parameter int TO_WIDTH      = 8
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  wb_dsp_arbiter_if.slave  m0,
  wb_dsp_arbiter_if.slave  m1,
  wb_dsp_arbiter_if.master s,
  output logic [1:0]       grant_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  logic [1:0]              state, next_state, pick;
  logic                    last_served, to_flag, g0, g1;
  logic                    cyc_mux, stb_mux, we_mux, counting, fire;
  logic [ADDR_WIDTH-1:0]   adr_mux;
  logic [DATA_WIDTH/8-1:0] sel_mux;
  logic [DATA_WIDTH-1:0]   dat_mux;
  logic [TO_WIDTH-1:0]     wd_cnt;
  // owner keeps the bus while its cyc is high; otherwise re-arbitrate in the same cycle
  always_comb begin
    g0 = state == GNT0;
    g1 = state == GNT1;
    pick = (m0.cyc && m1.cyc) ? ((PRIORITY_MODE != 0 || last_served) ? GNT0 : GNT1)
         : m0.cyc ? GNT0 : m1.cyc ? GNT1 : IDLE;
    next_state = (g0 && m0.cyc) ? GNT0 : (g1 && m1.cyc) ? GNT1 : pick;
  end
  // request mux toward the slave and watchdog fire condition
  always_comb begin
    cyc_mux  = g0 ? m0.cyc   : g1 ? m1.cyc   : 1'b0;
    stb_mux  = g0 ? m0.stb   : g1 ? m1.stb   : 1'b0;
    we_mux   = g0 ? m0.we    : g1 ? m1.we    : 1'b0;
    adr_mux  = g0 ? m0.adr   : g1 ? m1.adr   : '0;
    sel_mux  = g0 ? m0.sel   : g1 ? m1.sel   : '0;
    dat_mux  = g0 ? m0.dat_w : g1 ? m1.dat_w : '0;
    counting = cyc_mux && stb_mux && !to_flag && !s.ack && !s.err;
    fire     = TIMEOUT != 0 && counting && wd_cnt == TO_LAST;
  end
  assign s.cyc    = cyc_mux & ~to_flag;
  assign s.stb    = stb_mux & ~to_flag;
  assign s.we     = we_mux;
  assign s.adr    = adr_mux;
  assign s.sel    = sel_mux;
  assign s.dat_w  = dat_mux;
  assign m0.dat_r = g0 ? s.dat_r : '0;
  assign m0.ack   = g0 & s.ack;
  assign m0.err   = g0 & (s.err | to_flag);
  assign m1.dat_r = g1 ? s.dat_r : '0;
  assign m1.ack   = g1 & s.ack;
  assign m1.err   = g1 & (s.err | to_flag);
  // grant state, round-robin history, watchdog counter and its one-cycle error pulse
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state       <= IDLE;
      last_served <= 1'b1;
      wd_cnt      <= '0;
      to_flag     <= 1'b0;
      grant_o     <= 2'b00;
    end else begin
      state   <= next_state;
      grant_o <= {next_state == GNT1, next_state == GNT0};
      wd_cnt  <= (counting && !fire) ? wd_cnt + 1'b1 : '0;
      to_flag <= fire;
      if (g0 && !m0.cyc) last_served <= 1'b0;
      if (g1 && !m1.cyc) last_served <= 1'b1;
    end
  end
endmodule
